// File: rtl/ro_pkg.sv
// Shared types, default widths and the configuration sanity check for the row sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   RO_ROW_W / RO_CNT_W : default row-address and timing-counter widths
//   ro_state_t          : sequencer states IDLE and ROW
//   ro_cfg_ok()         : 1 when a frame configuration may be started
package ro_pkg;

  localparam int RO_ROW_W = 9;
  localparam int RO_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ROW  = 1'b1
  } ro_state_t;

  // Arguments are zero-extended to 32 bits by the caller. The last CP pulse
  // time is formed in 64 bits so cp_n*cp_per can never wrap into range.
  function automatic logic ro_cfg_ok(
    input logic [31:0] t_row,
    input logic [31:0] row_start,
    input logic [31:0] row_end,
    input logic [31:0] row_step,
    input logic [31:0] col_en_w,
    input logic [31:0] prech_w,
    input logic [31:0] cp_dly,
    input logic [31:0] cp_per,
    input logic [31:0] cp_n,
    input logic [31:0] pr_dly,
    input logic [31:0] pr_w
  );
    logic [63:0] cp_last;
    logic        ok;
    cp_last = {32'd0, cp_dly} + {32'd0, cp_n - 32'd1} * {32'd0, cp_per};
    ok = (t_row >= 32'd2) && (row_step != 32'd0) && (row_start <= row_end) &&
         (col_en_w <= t_row) && (prech_w <= t_row) &&
         (({1'b0, pr_dly} + {1'b0, pr_w}) <= {1'b0, t_row});
    if ((cp_n != 32'd0) && ((cp_per == 32'd0) || (cp_last >= {32'd0, t_row}))) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/ro_window.sv
// Registered window strobe: high while cnt_i lies in [start_i, start_i+width_i).
// Latency: output registers the compare of the inputs presented at the same edge.
// Backpressure: none; en_i low forces the strobe low.
//
// Ports:
//   clk_100, rst           : clock, synchronous active-high reset
//   en_i                   : window may assert (frame active in the coming cycle)
//   cnt_i, start_i, width_i: row-cycle count and window placement
//   win_o                  : registered window level
module ro_window
  import ro_pkg::*;
#(
  parameter int CNT_W = RO_CNT_W
) (
  input  logic             clk_100,
  input  logic             rst,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] start_i,
  input  logic [CNT_W-1:0] width_i,
  output logic             win_o
);

  logic [CNT_W:0] stop_w;
  logic           hit;
  logic           win_q;

  // One extra bit so start+width near the top of the range does not wrap.
  assign stop_w = {1'b0, start_i} + {1'b0, width_i};
  assign hit    = en_i && (cnt_i >= start_i) && ({1'b0, cnt_i} < stop_w);

  always_ff @(posedge clk_100) begin
    if (rst) begin
      win_q <= 1'b0;
    end else begin
      win_q <= hit;
    end
  end

  assign win_o = win_q;

endmodule

// File: rtl/ro_row_seq.sv
// Readout row sequencer: steps ROWADD over a frame and times column/pixel strobes per row.
// Latency: trigger at edge k -> busy and row cycle t=0 outputs in cycle k+1; all outputs registered.
// Backpressure: none; trigger while busy is ignored, abort ends the frame at the next edge.
//
// Ports:
//   clk_100, rst                       : clock, synchronous active-high reset
//   trigger, abort                     : frame start request / immediate stop
//   row_start, row_end, row_step       : row range (inclusive) and increment
//   t_row, col_en_w, prech_w, cp_*,
//   pr_dly, pr_w, pga_en               : per-row timing, latched when a frame starts
//   busy, err, frame_done              : status (err and frame_done are 1-cycle pulses)
//   ROWADD, COL_L_EN, COL_PRECH,
//   CP_MUX_IN, PIXRES, PGA_RES         : row address and strobes
// Build option: READOUT_PGA_EN drives PGA_RES from the PIXRES window gated by pga_en;
// without it PGA_RES is held 0 and pga_en is ignored.
module ro_row_seq
  import ro_pkg::*;
#(
  parameter int ROW_W = RO_ROW_W,
  parameter int CNT_W = RO_CNT_W
) (
  input  logic             clk_100,
  input  logic             rst,
  input  logic             trigger,
  input  logic             abort,
  input  logic [ROW_W-1:0] row_start,
  input  logic [ROW_W-1:0] row_end,
  input  logic [ROW_W-1:0] row_step,
  input  logic [CNT_W-1:0] t_row,
  input  logic [CNT_W-1:0] col_en_w,
  input  logic [CNT_W-1:0] prech_w,
  input  logic [CNT_W-1:0] cp_dly,
  input  logic [CNT_W-1:0] cp_per,
  input  logic [CNT_W-1:0] cp_n,
  input  logic [CNT_W-1:0] pr_dly,
  input  logic [CNT_W-1:0] pr_w,
  input  logic             pga_en,
  output logic             busy,
  output logic             err,
  output logic             frame_done,
  output logic [ROW_W-1:0] ROWADD,
  output logic             COL_L_EN,
  output logic             COL_PRECH,
  output logic             CP_MUX_IN,
  output logic             PIXRES,
  output logic             PGA_RES
);

  ro_state_t        state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W:0]   row_nxt;
  logic             busy_q, err_q, err_d, done_q, done_d, cp_q;
  logic             load, active_d, row_begin, cp_hit;

  // Latched frame configuration.
  logic [ROW_W-1:0] row_end_q, row_end_d, row_step_q, row_step_d;
  logic [CNT_W-1:0] t_row_q, t_row_d, col_en_w_q, col_en_w_d, prech_w_q, prech_w_d;
  logic [CNT_W-1:0] cp_dly_q, cp_dly_d, cp_per_q, cp_per_d, cp_n_q, cp_n_d;
  logic [CNT_W-1:0] pr_dly_q, pr_dly_d, pr_w_q, pr_w_d;

  // CP pulse tracking: time of the next pulse and pulses left in this row.
  logic [CNT_W:0]   cp_nxt_q, cp_nxt_d, cp_base_t;
  logic [CNT_W-1:0] cp_left_q, cp_left_d, cp_base_n;

  logic cfg_ok;
  assign cfg_ok = ro_cfg_ok(32'(t_row), 32'(row_start), 32'(row_end), 32'(row_step),
                            32'(col_en_w), 32'(prech_w), 32'(cp_dly), 32'(cp_per),
                            32'(cp_n), 32'(pr_dly), 32'(pr_w));

  // Next row in ROW_W+1 bits: a step past the top of the address space ends the
  // frame instead of wrapping back to a low row.
  assign row_nxt = {1'b0, row_q} + {1'b0, row_step_q};

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    row_d   = row_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          if (cfg_ok) begin
            load    = 1'b1;
            state_d = ROW;
            t_d     = '0;
            row_d   = row_start;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ROW: begin
        if (abort) begin
          state_d = IDLE;
          t_d     = '0;
        end else if (t_q == t_row_q - CNT_W'(1)) begin
          t_d = '0;
          if (row_nxt <= {1'b0, row_end_q}) begin
            row_d = row_nxt[ROW_W-1:0];
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          t_d = t_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Config seen by the strobe logic in the coming cycle: fresh inputs on the
  // starting edge, latched copy otherwise.
  always_comb begin
    row_end_d  = load ? row_end  : row_end_q;
    row_step_d = load ? row_step : row_step_q;
    t_row_d    = load ? t_row    : t_row_q;
    col_en_w_d = load ? col_en_w : col_en_w_q;
    prech_w_d  = load ? prech_w  : prech_w_q;
    cp_dly_d   = load ? cp_dly   : cp_dly_q;
    cp_per_d   = load ? cp_per   : cp_per_q;
    cp_n_d     = load ? cp_n     : cp_n_q;
    pr_dly_d   = load ? pr_dly   : pr_dly_q;
    pr_w_d     = load ? pr_w     : pr_w_q;
  end

  assign active_d  = (state_d == ROW);
  assign row_begin = active_d && (t_d == '0);

  // Pulse schedule restarts at t=0 of every row; each hit advances by cp_per.
  always_comb begin
    cp_base_t = row_begin ? {1'b0, cp_dly_d} : cp_nxt_q;
    cp_base_n = row_begin ? cp_n_d : cp_left_q;
    cp_hit    = active_d && (cp_base_n != '0) && ({1'b0, t_d} == cp_base_t);
    cp_nxt_d  = cp_hit ? cp_base_t + {1'b0, cp_per_d} : cp_base_t;
    cp_left_d = cp_hit ? cp_base_n - CNT_W'(1) : cp_base_n;
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q    <= IDLE;
      t_q        <= '0;
      row_q      <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      cp_q       <= 1'b0;
      cp_nxt_q   <= '0;
      cp_left_q  <= '0;
      row_end_q  <= '0;
      row_step_q <= '0;
      t_row_q    <= '0;
      col_en_w_q <= '0;
      prech_w_q  <= '0;
      cp_dly_q   <= '0;
      cp_per_q   <= '0;
      cp_n_q     <= '0;
      pr_dly_q   <= '0;
      pr_w_q     <= '0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      row_q      <= row_d;
      busy_q     <= active_d;
      err_q      <= err_d;
      done_q     <= done_d;
      cp_q       <= cp_hit;
      cp_nxt_q   <= cp_nxt_d;
      cp_left_q  <= cp_left_d;
      row_end_q  <= row_end_d;
      row_step_q <= row_step_d;
      t_row_q    <= t_row_d;
      col_en_w_q <= col_en_w_d;
      prech_w_q  <= prech_w_d;
      cp_dly_q   <= cp_dly_d;
      cp_per_q   <= cp_per_d;
      cp_n_q     <= cp_n_d;
      pr_dly_q   <= pr_dly_d;
      pr_w_q     <= pr_w_d;
    end
  end

  ro_window #(.CNT_W(CNT_W)) u_col_en (
    .clk_100(clk_100), .rst(rst), .en_i(active_d), .cnt_i(t_d),
    .start_i('0), .width_i(col_en_w_d), .win_o(COL_L_EN)
  );

  ro_window #(.CNT_W(CNT_W)) u_prech (
    .clk_100(clk_100), .rst(rst), .en_i(active_d), .cnt_i(t_d),
    .start_i('0), .width_i(prech_w_d), .win_o(COL_PRECH)
  );

  ro_window #(.CNT_W(CNT_W)) u_pixres (
    .clk_100(clk_100), .rst(rst), .en_i(active_d), .cnt_i(t_d),
    .start_i(pr_dly_d), .width_i(pr_w_d), .win_o(PIXRES)
  );

`ifdef READOUT_PGA_EN
  logic pga_q, pga_d;
  assign pga_d = load ? pga_en : pga_q;

  always_ff @(posedge clk_100) begin
    if (rst) begin
      pga_q <= 1'b0;
    end else begin
      pga_q <= pga_d;
    end
  end

  // Same window as PIXRES, gated by the pga_en captured at frame start.
  ro_window #(.CNT_W(CNT_W)) u_pga (
    .clk_100(clk_100), .rst(rst), .en_i(active_d && pga_d), .cnt_i(t_d),
    .start_i(pr_dly_d), .width_i(pr_w_d), .win_o(PGA_RES)
  );
`else
  logic unused_pga_en;
  assign unused_pga_en = pga_en;
  assign PGA_RES       = 1'b0;
`endif

  assign busy       = busy_q;
  assign err        = err_q;
  assign frame_done = done_q;
  assign ROWADD     = row_q;
  assign CP_MUX_IN  = cp_q;

endmodule

// File: tb/tb_ro_row_seq.sv
// Self-checking bench for ro_row_seq: directed frames plus randomized traffic
// compared cycle by cycle against a frame-offset reference model.
module tb_ro_row_seq;

  localparam int ROW_W = 9;
  localparam int CNT_W = 16;

  logic clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  logic             rst, trigger, abort, pga_en;
  logic [ROW_W-1:0] row_start, row_end, row_step;
  logic [CNT_W-1:0] t_row, col_en_w, prech_w, cp_dly, cp_per, cp_n, pr_dly, pr_w;
  logic             busy, err, frame_done;
  logic [ROW_W-1:0] ROWADD;
  logic             COL_L_EN, COL_PRECH, CP_MUX_IN, PIXRES, PGA_RES;

  ro_row_seq dut (
    .clk_100(clk_100), .rst(rst), .trigger(trigger), .abort(abort),
    .row_start(row_start), .row_end(row_end), .row_step(row_step),
    .t_row(t_row), .col_en_w(col_en_w), .prech_w(prech_w),
    .cp_dly(cp_dly), .cp_per(cp_per), .cp_n(cp_n),
    .pr_dly(pr_dly), .pr_w(pr_w), .pga_en(pga_en),
    .busy(busy), .err(err), .frame_done(frame_done), .ROWADD(ROWADD),
    .COL_L_EN(COL_L_EN), .COL_PRECH(COL_PRECH), .CP_MUX_IN(CP_MUX_IN),
    .PIXRES(PIXRES), .PGA_RES(PGA_RES)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is just an offset from its first cycle; row and
  // in-row time come from division by the row period.
  bit m_busy;
  int m_off, m_nrows, m_trow, m_rs, m_rstep, m_row;
  int m_col, m_pre, m_cpd, m_cpp, m_cpn, m_prd, m_prw;
  bit m_pga;
  bit e_busy, e_err, e_done;
  logic [4:0] e_str;

  function automatic bit m_ok();
    longint tr;
    tr = longint'(t_row);
    if (tr < 2) return 1'b0;
    if (row_step == '0) return 1'b0;
    if (row_start > row_end) return 1'b0;
    if (col_en_w > t_row || prech_w > t_row) return 1'b0;
    if (longint'(pr_dly) + longint'(pr_w) > tr) return 1'b0;
    if (cp_n != '0) begin
      if (cp_per == '0) return 1'b0;
      if (longint'(cp_dly) + (longint'(cp_n) - 1) * longint'(cp_per) >= tr) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic m_step();
    int  t;
    bit  col, pre, cp, pix, pga;
    e_err  = 1'b0;
    e_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_row  = 0;
      m_off  = 0;
    end else if (m_busy) begin
      if (abort) m_busy = 1'b0;
      else if (m_off + 1 == m_nrows * m_trow) begin
        m_busy = 1'b0;
        e_done = 1'b1;
      end else m_off++;
    end else if (trigger) begin
      if (m_ok()) begin
        m_trow  = int'(t_row);
        m_rs    = int'(row_start);
        m_rstep = int'(row_step);
        m_nrows = (int'(row_end) - int'(row_start)) / int'(row_step) + 1;
        m_col = int'(col_en_w); m_pre = int'(prech_w);
        m_cpd = int'(cp_dly); m_cpp = int'(cp_per); m_cpn = int'(cp_n);
        m_prd = int'(pr_dly); m_prw = int'(pr_w); m_pga = pga_en;
        m_busy = 1'b1;
        m_off  = 0;
      end else e_err = 1'b1;
    end
    col = 0; pre = 0; cp = 0; pix = 0; pga = 0;
    if (m_busy) begin
      m_row = m_rs + (m_off / m_trow) * m_rstep;
      t   = m_off % m_trow;
      col = (t < m_col);
      pre = (t < m_pre);
      pix = (t >= m_prd) && (t < m_prd + m_prw);
      cp  = (m_cpn > 0) && (m_cpp > 0) && (t >= m_cpd) &&
            (((t - m_cpd) % m_cpp) == 0) && (((t - m_cpd) / m_cpp) < m_cpn);
`ifdef READOUT_PGA_EN
      pga = pix && m_pga;
`endif
    end
    e_busy = m_busy;
    e_str  = {col, pre, cp, pix, pga};
  endtask

  // One clock: drive inputs for the coming edge, advance the model, compare.
  task automatic cyc(input bit r, input bit t, input bit a);
    rst = r; trigger = t; abort = a;
    m_step();
    @(posedge clk_100);
    @(negedge clk_100);
    chk("busy", longint'(busy), longint'(e_busy));
    chk("err", longint'(err), longint'(e_err));
    chk("frame_done", longint'(frame_done), longint'(e_done));
    chk("rowadd", longint'(ROWADD), longint'(m_row));
    chk("strobes", longint'({COL_L_EN, COL_PRECH, CP_MUX_IN, PIXRES, PGA_RES}), longint'(e_str));
  endtask

  task automatic set_cfg(input int rs, input int re, input int st, input int tr,
                         input int col, input int pre, input int cpd, input int cpp,
                         input int cpn, input int prd, input int prw, input bit pga);
    row_start = ROW_W'(rs); row_end = ROW_W'(re); row_step = ROW_W'(st);
    t_row = CNT_W'(tr); col_en_w = CNT_W'(col); prech_w = CNT_W'(pre);
    cp_dly = CNT_W'(cpd); cp_per = CNT_W'(cpp); cp_n = CNT_W'(cpn);
    pr_dly = CNT_W'(prd); pr_w = CNT_W'(prw); pga_en = pga;
  endtask

  task automatic rand_cfg();
    int tr, rs, re, prd;
    tr  = int'($urandom_range(1, 12));
    rs  = int'($urandom_range(0, 511));
    if ($urandom_range(0, 7) == 0) re = (rs + 511) % 512;
    else begin
      re = rs + int'($urandom_range(0, 6));
      if (re > 511) re = 511;
    end
    prd = int'($urandom_range(0, tr));
    set_cfg(rs, re, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4)), tr,
            int'($urandom_range(0, tr)), int'($urandom_range(0, tr)),
            int'($urandom_range(0, tr)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
            prd, int'($urandom_range(0, tr - prd + (($urandom_range(0, 9) == 0) ? 1 : 0))),
            1'($urandom_range(0, 1)));
  endtask

  initial begin
    int nb, ncol, ncp, nd, npga, nbad;
    set_cfg(0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    m_busy = 0; m_row = 0; m_off = 0;
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("reset_busy", longint'(busy), 0);
    cyc(0, 0, 0);

    // Frame of rows 2,4,6 with 20-cycle rows; inputs scrambled after the start.
    set_cfg(2, 6, 2, 20, 10, 3, 3, 4, 3, 5, 2, 1'b1);
    nb = 0; ncol = 0; ncp = 0; nd = 0; npga = 0;
    cyc(0, 1, 0);
    set_cfg(100, 3, 0, 5, 1, 1, 0, 1, 1, 0, 1, 1'b0);
    for (int i = 0; i < 66; i++) begin
      nb += int'(busy); ncol += int'(COL_L_EN); ncp += int'(CP_MUX_IN);
      nd += int'(frame_done); npga += int'(PGA_RES);
      cyc(0, 0, 0);
    end
    chk("frame_busy_cycles", nb, 60);
    chk("frame_col_cycles", ncol, 30);
    chk("frame_cp_pulses", ncp, 9);
    chk("frame_done_count", nd, 1);
`ifdef READOUT_PGA_EN
    chk("frame_pga_cycles", npga, 6);
`else
    chk("frame_pga_cycles", npga, 0);
`endif

    // Rejected configs: last CP pulse at t_row, then an inverted row range.
    set_cfg(0, 3, 1, 20, 0, 0, 10, 5, 3, 0, 0, 1'b0);
    cyc(0, 1, 0);
    chk("err_cp_range", longint'(err), 1);
    cyc(0, 0, 0);
    set_cfg(5, 4, 1, 20, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    cyc(0, 1, 0);
    chk("err_row_range", longint'(err), 1);
    cyc(0, 0, 0);

    // Abort at row 2, t=7, then a fresh trigger three cycles later.
    set_cfg(0, 3, 1, 20, 10, 4, 3, 4, 3, 5, 2, 1'b1);
    cyc(0, 1, 0);
    for (int i = 0; i < 47; i++) cyc(0, 0, 0);
    chk("abort_row", longint'(ROWADD), 2);
    cyc(0, 0, 1);
    chk("abort_busy", longint'(busy), 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    nd = 0;
    for (int i = 0; i < 82; i++) begin
      nd += int'(frame_done);
      cyc(0, 0, 0);
    end
    chk("restart_done_count", nd, 1);

    // Top of the address range: one row only, no wrap.
    set_cfg(510, 511, 4, 4, 2, 1, 1, 1, 2, 0, 1, 1'b1);
    nb = 0; nbad = 0;
    cyc(0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      nb += int'(busy);
      if (busy && ROWADD != 9'd510) nbad++;
      cyc(0, 0, 0);
    end
    chk("top_row_busy_cycles", nb, 4);
    chk("top_row_other_rows", nbad, 0);

    // Trigger held as a level: frames restart in the frame_done cycle.
    set_cfg(7, 7, 1, 2, 1, 2, 0, 1, 2, 1, 1, 1'b1);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    // Randomized traffic.
    rand_cfg();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rand_cfg();
      cyc($urandom_range(0, 999) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ro_row_seq.md
RO_ROW_SEQ -- requirements
Module: ro_row_seq

Interface
REQ-001 ROW_W, 9, row address width.
REQ-002 CNT_W, 16, width of every timing counter and timing input.
REQ-003 clk_100  in  1  system clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 trigger  in  1  frame start request; one-cycle pulse or level.
REQ-006 abort  in  1  stop the frame immediately.
REQ-007 row_start  in  ROW_W  first row of the frame.
REQ-008 row_end  in  ROW_W  last row allowed; inclusive.
REQ-009 row_step  in  ROW_W  row increment; 1 means every row, 2 means every other row.
REQ-010 t_row  in  CNT_W  row period in cycles.
REQ-011 col_en_w  in  CNT_W  COL_L_EN width, starting at row cycle t=0.
REQ-012 prech_w  in  CNT_W  COL_PRECH width, starting at t=0.
REQ-013 cp_dly  in  CNT_W  t of the first CP_MUX_IN pulse.
REQ-014 cp_per  in  CNT_W  CP_MUX_IN pulse period.
REQ-015 cp_n  in  CNT_W  CP_MUX_IN pulses per row; 0 means none.
REQ-016 pr_dly  in  CNT_W  PIXRES rising t.
REQ-017 pr_w  in  CNT_W  PIXRES width.
REQ-018 pga_en  in  1  enables PGA_RES.
REQ-019 busy  out  1  frame in progress.
REQ-020 err  out  1  one-cycle pulse when a config is rejected.
REQ-021 frame_done  out  1  one-cycle pulse at normal frame end.
REQ-022 ROWADD  out  ROW_W  current row address.
REQ-023 COL_L_EN, COL_PRECH, CP_MUX_IN, PIXRES  out  1 each  column/pixel strobes.
REQ-024 PGA_RES  out  1  PGA reset strobe.

Function
REQ-025 All outputs are registered; states are IDLE and ROW (ro_state_t); row cycle counter t runs 0..t_row-1; every strobe reflects the t of the same cycle.
REQ-026 Trigger seen high in IDLE at edge k: all timing and row inputs are latched at edge k; busy=1 and t=0 of the first row appear in cycle k+1; later input changes have no effect until the next frame.
REQ-027 Config is rejected if t_row<2, row_step=0, row_start>row_end, col_en_w>t_row, prech_w>t_row, pr_dly+pr_w>t_row, or (cp_n>0 and (cp_per=0 or cp_dly+(cp_n-1)*cp_per>=t_row)); on rejection err pulses in cycle k+1 and the block stays IDLE.
REQ-028 Windows are half-open [start, start+width): COL_L_EN over [0,col_en_w), COL_PRECH over [0,prech_w), PIXRES over [pr_dly,pr_dly+pr_w); a width of 0 means never asserted.
REQ-029 CP_MUX_IN is a one-cycle pulse at t=cp_dly+i*cp_per for i=0..cp_n-1.
REQ-030 ROWADD equals the current row for the whole row; rows are row_start, +row_step, and so on while the row is <=row_end; the next row is computed in ROW_W+1 bits so the address never wraps.
REQ-031 After t=t_row-1 of the last row: frame_done=1 and busy=0 in the next cycle, all strobes 0, ROWADD holds the last row.
REQ-032 Trigger while busy is ignored; trigger in the frame_done cycle is honoured, so a new frame starts in the following cycle.
REQ-033 abort high at edge m while busy: from cycle m+1 the block is IDLE, busy=0, all strobes 0, and no frame_done; abort has priority over row advance; abort in IDLE has no effect.

Reset
REQ-034 On rst: IDLE, busy/err/frame_done/ROWADD/all strobes 0, latched config cleared; rst mid-frame truncates the frame with no frame_done.

Configuration
REQ-035 With READOUT_PGA_EN defined: PGA_RES = PIXRES window AND pga_en as latched at trigger. Without it, PGA_RES is tied 0, pga_en is unused, and the port list is unchanged.

Structure
REQ-036 Package ro_pkg holds ro_state_t, the default ROW_W/CNT_W constants, and the config-check function.
REQ-037 A single sub-module ro_window (counter compare to [start,start+width) -> registered level) is instantiated for COL_L_EN, COL_PRECH and PIXRES.

Verification
REQ-038 row_start=2, row_end=6, row_step=2, t_row=20 -> ROWADD sequence 2,4,6 with 20 cycles per row; busy high for 60 cycles; frame_done 1 cycle after the end.
REQ-039 cp_dly=3, cp_per=4, cp_n=3, t_row=20 -> CP_MUX_IN at t=3,7,11 in every row; col_en_w=10 gives COL_L_EN high for exactly 10 cycles.
REQ-040 cp_dly=10, cp_per=5, cp_n=3, t_row=20 -> err pulse, busy stays 0; row_start=5, row_end=4 -> err.
REQ-041 abort asserted at row 2, t=7 -> next cycle busy=0, all strobes 0, no frame_done; a trigger 3 cycles later starts a clean frame.
REQ-042 row_start=510, row_end=511, row_step=4, ROW_W=9 -> exactly one row (510), no wrap to row 2.
REQ-043 READOUT_PGA_EN defined, pga_en=1, pr_dly=5, pr_w=2 -> PGA_RES high at t=5,6; with pga_en=0, or the macro undefined, PGA_RES stays 0.
